// File: rtl/join_sync_ctrl.sv
// I/Q join sequencer: merges the two sample streams beat-for-beat and realigns
// them on packet boundaries by draining the lagging stream when tlast markers disagree.
module join_sync_ctrl #(
   parameter int SR_CTRL = 130,
   parameter int WIDTH   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set_stb,
   input  logic [7:0]       set_addr,
   input  logic [31:0]      set_data,
   input  logic [WIDTH-1:0] i0_tdata,
   input  logic             i0_tlast,
   input  logic             i0_tvalid,
   output logic             i0_tready,
   input  logic [WIDTH-1:0] i1_tdata,
   input  logic             i1_tlast,
   input  logic             i1_tvalid,
   output logic             i1_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready,
   output logic [31:0]      pkt_count,
   output logic [15:0]      mismatch_count,
   output logic [1:0]       state
);

   localparam int         HALF      = WIDTH / 2;
   localparam logic [7:0] CTRL_ADDR = 8'(SR_CTRL);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN0 = 2'd2,
      ST_DRAIN1 = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_enable;
   logic [WIDTH-1:0]  r_o_tdata;
   logic              r_o_tlast;
   logic              r_o_tvalid;
   logic [31:0]       r_pkt_count;
   logic [15:0]       r_mismatch_count;

   logic w_ctrl_wr;
   logic w_clear;
   logic w_out_free;
   logic w_fire;
   logic w_pkt_inc;
   logic w_mis_inc;
   logic w_unused_bits;

   assign w_ctrl_wr  = set_stb & (set_addr == CTRL_ADDR);
   assign w_clear    = w_ctrl_wr & set_data[1];
   assign w_out_free = ~r_o_tvalid | o_tready;
   assign w_fire     = (r_state == ST_RUN) & i0_tvalid & i1_tvalid & w_out_free;
   // A packet ends on either tlast; disagreement between them is a resync event.
   assign w_pkt_inc  = w_fire & (i0_tlast | i1_tlast);
   assign w_mis_inc  = w_fire & (i0_tlast ^ i1_tlast);

   assign i0_tready  = w_fire | (r_state == ST_DRAIN0);
   assign i1_tready  = w_fire | (r_state == ST_DRAIN1);

   assign w_unused_bits = &{1'b0, set_data[31:2], i0_tdata[HALF-1:0], i1_tdata[HALF-1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_enable <= 1'b0;
      end else if (w_ctrl_wr) begin
         r_enable <= set_data[0];
      end else begin
         r_enable <= r_enable;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_enable) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (w_fire) begin
                  if (i0_tlast & i1_tlast) begin
                     if (!r_enable) r_state <= ST_IDLE;
                  end else if (i0_tlast) begin
                     r_state <= ST_DRAIN1;
                  end else if (i1_tlast) begin
                     r_state <= ST_DRAIN0;
                  end
               end
            end
            ST_DRAIN0: begin
               if (i0_tvalid & i0_tlast) r_state <= r_enable ? ST_RUN : ST_IDLE;
            end
            ST_DRAIN1: begin
               if (i1_tvalid & i1_tlast) r_state <= r_enable ? ST_RUN : ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_o_tdata  <= '0;
         r_o_tlast  <= 1'b0;
         r_o_tvalid <= 1'b0;
      end else if (w_fire) begin
         r_o_tdata  <= {i0_tdata[WIDTH-1 -: HALF], i1_tdata[WIDTH-1 -: HALF]};
         r_o_tlast  <= i0_tlast | i1_tlast;
         r_o_tvalid <= 1'b1;
      end else if (o_tready) begin
         r_o_tvalid <= 1'b0;
      end else begin
         r_o_tvalid <= r_o_tvalid;
      end
   end

   // A clear coinciding with an increment leaves the counter at 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pkt_count      <= 32'd0;
         r_mismatch_count <= 16'd0;
      end else begin
         if (w_clear)        r_pkt_count <= {31'd0, w_pkt_inc};
         else if (w_pkt_inc) r_pkt_count <= r_pkt_count + 32'd1;
         else                r_pkt_count <= r_pkt_count;

         if (w_clear)
            r_mismatch_count <= {15'd0, w_mis_inc};
         else if (w_mis_inc && (r_mismatch_count != 16'hFFFF))
            r_mismatch_count <= r_mismatch_count + 16'd1;
         else
            r_mismatch_count <= r_mismatch_count;
      end
   end

   assign o_tdata        = r_o_tdata;
   assign o_tlast        = r_o_tlast;
   assign o_tvalid       = r_o_tvalid;
   assign pkt_count      = r_pkt_count;
   assign mismatch_count = r_mismatch_count;
   assign state          = r_state;

endmodule
